pipe_hazard_ctrl: RTL and testbench

Pipeline hazard and memory-wait sequencer for the 5-stage MIPS core. Sits beside the main decode `Control` unit and drives the pipeline-register write enables, the flush and bubble controls, and the data-memory request. It resolves three conditions:
- load-use hazards, with a one-cycle bubble;
- taken beq/j, by flushing IF/ID;
- multi-cycle data-memory accesses, by freezing the whole pipe until `mem_ack_i` arrives or a timeout expires.

---
 rtl/pipe_hazard_ctrl_if.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the MIPS core datapath (master) and the
// hazard/memory-wait sequencer (slave).
interface pipe_hazard_ctrl_if;
  logic [4:0] IF_ID_rs_i;
  logic [4:0] IF_ID_rt_i;
  logic [4:0] ID_EX_rt_i;
  logic       ID_EX_MemRead_i;
  logic       branch_i;
  logic       branch_taken_i;
  logic       jump_i;
  logic       EX_MEM_memacc_i;
  logic       mem_ack_i;
  logic       pc_write_o;
  logic       if_id_write_o;
  logic       if_id_flush_o;
  logic       id_ex_bubble_o;
  logic       pipe_hold_o;
  logic       mem_req_o;
  logic       mem_err_o;

  modport master (
    output IF_ID_rs_i, IF_ID_rt_i, ID_EX_rt_i, ID_EX_MemRead_i,
           branch_i, branch_taken_i, jump_i, EX_MEM_memacc_i, mem_ack_i,
    input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
           pipe_hold_o, mem_req_o, mem_err_o
  );

  modport slave (
    input  IF_ID_rs_i, IF_ID_rt_i, ID_EX_rt_i, ID_EX_MemRead_i,
           branch_i, branch_taken_i, jump_i, EX_MEM_memacc_i, mem_ack_i,
    output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
           pipe_hold_o, mem_req_o, mem_err_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use bubble, taken-branch/jump flush and data-memory wait freeze for the
// 5-stage MIPS pipe. Optional stall counter enabled by HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
`ifdef HAZ_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipe_hazard_ctrl_if.slave  hz
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt_o
`endif
);

  typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_e;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;

  logic run, tmo_hit, freeze, timeout, load_use, xfer;

  always_comb begin
    run      = (state_q == RUN);
    tmo_hit  = (wait_q == TMO);
    freeze   = run ? (hz.EX_MEM_memacc_i & ~hz.mem_ack_i)
                   : (~hz.mem_ack_i & ~tmo_hit);
    timeout  = ~run & ~hz.mem_ack_i & tmo_hit;
    load_use = hz.ID_EX_MemRead_i && (hz.ID_EX_rt_i != 5'd0) &&
               ((hz.ID_EX_rt_i == hz.IF_ID_rs_i) || (hz.ID_EX_rt_i == hz.IF_ID_rt_i));
    xfer     = (hz.branch_i & hz.branch_taken_i) | hz.jump_i;
  end

  // Hazard checks also apply on the MEMWAIT release cycle, since the pipe
  // advances then and a held branch/load-use must not be lost.
  always_comb begin
    hz.pc_write_o     = 1'b0;
    hz.if_id_write_o  = 1'b0;
    hz.if_id_flush_o  = 1'b0;
    hz.id_ex_bubble_o = 1'b0;
    hz.pipe_hold_o    = 1'b0;
    hz.mem_req_o      = 1'b0;
    hz.mem_err_o      = 1'b0;
    if (rst_i) begin
      hz.pc_write_o     = ~freeze & ~load_use;
      hz.if_id_write_o  = ~freeze & ~load_use;
      hz.id_ex_bubble_o = ~freeze & load_use;
      hz.if_id_flush_o  = ~freeze & ~load_use & xfer;
      hz.pipe_hold_o    = freeze;
      hz.mem_req_o      = run ? hz.EX_MEM_memacc_i : 1'b1;
      hz.mem_err_o      = err_q | timeout;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q | timeout;
    if (run) begin
      if (hz.EX_MEM_memacc_i && !hz.mem_ack_i) begin
        state_d = MEMWAIT;
        wait_d  = 8'd1;
      end
    end else if (hz.mem_ack_i || tmo_hit) begin
      state_d = RUN;
      wait_d  = '0;
    end else if (wait_q != '1) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (!hz.pc_write_o && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: single-cycle hazard table plus
// memory-wait, timeout and mid-wait reset sequences (MEM_TIMEOUT = 4).
module tb_pipe_hazard_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipe_hazard_ctrl_if hz ();

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt;
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .hz(hz.slave), .stall_cnt_o(stall_cnt));
`else
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .hz(hz.slave));
`endif

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      name;
    logic [4:0] rs, rt, ex_rt;
    logic       memread, branch, taken, jump, memacc, ack;
    logic [6:0] exp;  // {pc_write, if_id_write, flush, bubble, hold, req, err}
  } vec_t;

  vec_t vecs [12];

  function automatic logic [6:0] outs();
    return {hz.pc_write_o, hz.if_id_write_o, hz.if_id_flush_o, hz.id_ex_bubble_o,
            hz.pipe_hold_o, hz.mem_req_o, hz.mem_err_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.IF_ID_rs_i = '0;  hz.IF_ID_rt_i = '0;  hz.ID_EX_rt_i = '0;
    hz.ID_EX_MemRead_i = 1'b0; hz.branch_i = 1'b0; hz.branch_taken_i = 1'b0;
    hz.jump_i = 1'b0; hz.EX_MEM_memacc_i = 1'b0; hz.mem_ack_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    //            name          rs  rt  exrt mr br tk j  ma ak  pc ifw fl bub hd rq er
    vecs[0]  = '{"idle",        0,  0,  0,   0, 0, 0, 0, 0, 0, 7'b1100000};
    vecs[1]  = '{"lu_rs",       2,  3,  2,   1, 0, 0, 0, 0, 0, 7'b0001000};
    vecs[2]  = '{"lu_rt",       1,  5,  5,   1, 0, 0, 0, 0, 0, 7'b0001000};
    vecs[3]  = '{"lu_r0",       0,  0,  0,   1, 0, 0, 0, 0, 0, 7'b1100000};
    vecs[4]  = '{"nomemread",   2,  0,  2,   0, 0, 0, 0, 0, 0, 7'b1100000};
    vecs[5]  = '{"beq_taken",   4,  6,  7,   0, 1, 1, 0, 0, 0, 7'b1110000};
    vecs[6]  = '{"beq_nottkn",  4,  6,  7,   0, 1, 0, 0, 0, 0, 7'b1100000};
    vecs[7]  = '{"jump",        0,  0,  0,   0, 0, 0, 1, 0, 0, 7'b1110000};
    vecs[8]  = '{"beq_lu",      2,  6,  2,   1, 1, 1, 0, 0, 0, 7'b0001000};
    vecs[9]  = '{"zero_wait",   0,  0,  0,   0, 0, 0, 0, 1, 1, 7'b1100010};
    vecs[10] = '{"stray_ack",   0,  0,  0,   0, 0, 0, 0, 0, 1, 7'b1100000};
    vecs[11] = '{"zw_jump",     0,  0,  0,   0, 0, 0, 1, 1, 1, 7'b1110010};

    clear_inputs();
    #2;
    chk("reset_outs", 32'(outs()), 32'd0);
    tick();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("post_reset", 32'(outs()), 32'(7'b1100000));
    tick();

    foreach (vecs[i]) begin
      hz.IF_ID_rs_i = vecs[i].rs;   hz.IF_ID_rt_i = vecs[i].rt;
      hz.ID_EX_rt_i = vecs[i].ex_rt; hz.ID_EX_MemRead_i = vecs[i].memread;
      hz.branch_i = vecs[i].branch; hz.branch_taken_i = vecs[i].taken;
      hz.jump_i = vecs[i].jump;     hz.EX_MEM_memacc_i = vecs[i].memacc;
      hz.mem_ack_i = vecs[i].ack;
      @(negedge clk_i);
      chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      tick();
    end
    clear_inputs();

    // Ack on 4th request cycle: 3 hold cycles, 4 request cycles.
    hz.EX_MEM_memacc_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) hz.mem_ack_i = 1'b1;
      @(negedge clk_i);
      chk($sformatf("ack4_hold%0d", i), 32'(hz.pipe_hold_o), (i < 3) ? 32'd1 : 32'd0);
      chk($sformatf("ack4_req%0d", i), 32'(hz.mem_req_o), 32'd1);
      chk($sformatf("ack4_pcw%0d", i), 32'(hz.pc_write_o), (i < 3) ? 32'd0 : 32'd1);
      tick();
    end
    clear_inputs();
    @(negedge clk_i);
    chk("ack4_after", 32'(outs()), 32'(7'b1100000));
    tick();

    // Timeout: 4 frozen cycles, then release with sticky error.
    hz.EX_MEM_memacc_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk($sformatf("tmo_hold%0d", i), 32'(hz.pipe_hold_o), (i < 4) ? 32'd1 : 32'd0);
      chk($sformatf("tmo_err%0d", i), 32'(hz.mem_err_o), (i < 4) ? 32'd0 : 32'd1);
      tick();
    end
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk($sformatf("tmo_sticky%0d", i), 32'(outs()), 32'(7'b1100001));
      tick();
    end

    // Reset pulsed during MEMWAIT.
    hz.EX_MEM_memacc_i = 1'b1;
    tick();
    tick();
    #2;
    chk("mw_hold_pre", 32'(hz.pipe_hold_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("mw_rst_outs", 32'(outs()), 32'd0);
    clear_inputs();
    tick();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("mw_rst_after", 32'(outs()), 32'(7'b1100000));
    tick();

`ifdef HAZ_PERF_CNT_EN
    hz.ID_EX_MemRead_i = 1'b1; hz.ID_EX_rt_i = 5'd2; hz.IF_ID_rs_i = 5'd2;
    tick();
    clear_inputs();
    hz.EX_MEM_memacc_i = 1'b1;
    tick();
    tick();
    tick();
    hz.mem_ack_i = 1'b1;
    tick();
    clear_inputs();
    @(negedge clk_i);
    chk("stall_cnt", 32'(stall_cnt), 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
